// File: rtl/mc_core_pkg.sv
// mc_core_pkg: opcodes, ALU control codes, FSM states and the halt word
// shared by mc_mips_core and mc_alu.
package mc_core_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_NOR  = 4'h4;
    localparam logic [3:0] OP_NAND = 4'h5;
    localparam logic [3:0] OP_SLT  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_BNE  = 4'h9;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NAND = 4'b1101;

    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;

    // Branches compare by subtraction; unknown opcodes fall back to add.
    function automatic logic [3:0] alu_ctrl(input logic [3:0] op);
        case (op)
            OP_ADD, OP_ADDI:        return ALU_ADD;
            OP_SUB, OP_BEQ, OP_BNE: return ALU_SUB;
            OP_AND:                 return ALU_AND;
            OP_OR:                  return ALU_OR;
            OP_NOR:                 return ALU_NOR;
            OP_NAND:                return ALU_NAND;
            OP_SLT:                 return ALU_SLT;
            default:                return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu.sv
// mc_alu: combinational DATA_W-bit ALU with a zero flag used for branch compares.
module mc_alu
    import mc_core_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        i_ctrl,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero
);

    logic [DATA_W-1:0] w_diff;
    logic              w_less;

    assign w_diff = i_a - i_b;
    // When the signs differ the sign of a decides; otherwise the difference cannot overflow.
    assign w_less = (i_a[DATA_W-1] ^ i_b[DATA_W-1]) ? i_a[DATA_W-1] : w_diff[DATA_W-1];

    always_comb begin
        o_result = i_a + i_b;
        case (i_ctrl)
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = w_diff;
            ALU_SLT:  o_result = {{(DATA_W-1){1'b0}}, w_less};
            ALU_NOR:  o_result = ~(i_a | i_b);
            ALU_NAND: o_result = ~(i_a & i_b);
            default:  o_result = i_a + i_b;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/mc_mips_core.sv
// mc_mips_core: multi-cycle FETCH/DECODE/EXEC/WB 16-bit-ISA core with handshaked imem.
// Define MC_CORE_PERF_EN to add saturating perf_cycles/perf_instrs counters.
module mc_mips_core
    import mc_core_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int IMEM_AW = 10
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [15:0]        imem_rdata,
    input  logic               imem_rvalid,
    output logic [IMEM_AW:0]   pc,
    output logic [15:0]        ir,
    output logic [DATA_W-1:0]  alu_out,
    output logic               retire,
    output logic               halted
`ifdef MC_CORE_PERF_EN
    ,
    output logic [31:0]        perf_cycles,
    output logic [31:0]        perf_instrs
`endif
);

    state_t            r_state;
    state_t            w_next;
    logic [IMEM_AW:0]  r_pc;
    logic [15:0]       r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_alu;
    logic              r_zero;
    logic              r_halted;
    logic [DATA_W-1:0] r_regs [4];

    logic [3:0]        w_op;
    logic [1:0]        w_rs;
    logic [1:0]        w_rt;
    logic [1:0]        w_rd;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_zero;
    logic [3:0]        w_alu_ctrl;
    logic              w_wr_en;
    logic [1:0]        w_wr_addr;
    logic              w_taken;
    logic [IMEM_AW:0]  w_pc_inc;
    logic [IMEM_AW:0]  w_br_target;

    assign w_op       = r_ir[15:12];
    assign w_rs       = r_ir[11:10];
    assign w_rt       = r_ir[9:8];
    assign w_rd       = r_ir[7:6];
    assign w_imm      = {{(DATA_W-8){r_ir[7]}}, r_ir[7:0]};
    assign w_rs_val   = (w_rs == 2'd0) ? '0 : r_regs[w_rs];
    assign w_rt_val   = (w_rt == 2'd0) ? '0 : r_regs[w_rt];
    assign w_alu_ctrl = alu_ctrl(w_op);

    assign w_pc_inc    = r_pc + (IMEM_AW+1)'(2);
    assign w_br_target = w_pc_inc + (IMEM_AW+1)'({{23{r_ir[7]}}, r_ir[7:0], 1'b0});
    assign w_taken     = ((w_op == OP_BEQ) && r_zero) || ((w_op == OP_BNE) && !r_zero);
    assign w_wr_en     = (w_op <= OP_SLT) || (w_op == OP_ADDI);
    assign w_wr_addr   = (w_op == OP_ADDI) ? w_rt : w_rd;

    mc_alu #(.DATA_W(DATA_W)) u_alu (
        .i_ctrl   (w_alu_ctrl),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_res),
        .o_zero   (w_alu_zero)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:   if (imem_rvalid) w_next = DECODE;
            DECODE:  w_next = (r_ir == HALT_WORD) ? HALT : EXEC;
            EXEC:    w_next = WB;
            WB:      w_next = FETCH;
            HALT:    w_next = HALT;
            default: w_next = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= FETCH;
            r_pc     <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_alu    <= '0;
            r_zero   <= 1'b0;
            r_halted <= 1'b0;
            for (int i = 0; i < 4; i++) r_regs[i] <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                FETCH: if (imem_rvalid) r_ir <= imem_rdata;
                DECODE: begin
                    r_a <= w_rs_val;
                    r_b <= (w_op == OP_ADDI) ? w_imm : w_rt_val;
                    if (r_ir == HALT_WORD) r_halted <= 1'b1;
                end
                EXEC: begin
                    r_alu  <= w_alu_res;
                    r_zero <= w_alu_zero;
                end
                WB: begin
                    if (w_wr_en && (w_wr_addr != 2'd0)) r_regs[w_wr_addr] <= r_alu;
                    r_pc <= w_taken ? w_br_target : w_pc_inc;
                end
                default: ;
            endcase
        end
    end

    assign imem_req  = (r_state == FETCH);
    assign imem_addr = r_pc[IMEM_AW:1];
    assign pc        = r_pc;
    assign ir        = r_ir;
    assign alu_out   = r_alu;
    assign retire    = (r_state == WB);
    assign halted    = r_halted;

`ifdef MC_CORE_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_cycles <= '0;
            perf_instrs <= '0;
        end else begin
            if (!r_halted && (perf_cycles != '1)) perf_cycles <= perf_cycles + 32'd1;
            if (retire && (perf_instrs != '1)) perf_instrs <= perf_instrs + 32'd1;
        end
    end
`endif

endmodule
